tb_uart: RTL and testbench

TB_UART -- requirements
Module: tb_uart

---
 rtl/tb_uart_pkg.sv | 17 +
 rtl/tb_uart_rx.sv | 92 +++++++++
 rtl/tb_uart.sv | 107 ++++++++++
 tb/tb_tb_uart.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_uart_pkg.sv
// rtl/tb_uart_pkg.sv - shared state encodings and frame constants for tb_uart
package tb_uart_pkg;

  localparam int FRAME_BITS = 10;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/tb_uart_rx.sv
// rtl/tb_uart_rx.sv - 8N1 receiver with input synchronizer and false-start rejection
module tb_uart_rx
  import tb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]  rx_sync;
  logic        rx_prev;
  logic        rx_line;
  logic [2:0]  rx_state;
  logic [15:0] rx_clk_cnt;
  logic [2:0]  rx_bit_idx;
  logic [7:0]  rx_shreg;

  assign rx_line = rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync      <= 2'b11;
      rx_prev      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_clk_cnt   <= 16'd0;
      rx_bit_idx   <= 3'd0;
      rx_shreg     <= 8'd0;
      rx_data      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync      <= {rx_sync[0], ser_rx};
      rx_prev      <= rx_line;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_clk_cnt <= 16'd0;
          rx_bit_idx <= 3'd0;
          if (rx_prev && !rx_line) rx_state <= RX_START;
        end
        RX_START: begin
          // Re-check mid start bit; a line already back high was only a glitch.
          if (rx_clk_cnt == HALF_LAST) begin
            rx_clk_cnt <= 16'd0;
            rx_state   <= rx_line ? RX_IDLE : RX_DATA;
          end else begin
            rx_clk_cnt <= rx_clk_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_clk_cnt == BIT_LAST) begin
            rx_clk_cnt <= 16'd0;
            rx_shreg   <= {rx_line, rx_shreg[7:1]};
            rx_bit_idx <= rx_bit_idx + 3'd1;
            if (rx_bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_clk_cnt <= rx_clk_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_clk_cnt == BIT_LAST) begin
            rx_clk_cnt <= 16'd0;
            if (rx_line) begin
              rx_data  <= rx_shreg;
              rx_valid <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_WAIT_HIGH;
            end
          end else begin
            rx_clk_cnt <= rx_clk_cnt + 16'd1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_line) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tb_uart.sv
// rtl/tb_uart.sv - 8N1 UART with edge-started transmitter and independent receiver
module tb_uart
  import tb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  logic        tx_start_q;
  logic        tx_armed;
  logic [1:0]  tx_state;
  logic [15:0] tx_clk_cnt;
  logic [2:0]  tx_bit_idx;
  logic [7:0]  tx_shreg;

  // tx_start_q resets high so a request held through reset is not seen as a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start_q   <= 1'b1;
      tx_armed     <= 1'b0;
      tx_state     <= TX_IDLE;
      tx_clk_cnt   <= 16'd0;
      tx_bit_idx   <= 3'd0;
      tx_shreg     <= 8'd0;
      ser_tx       <= 1'b1;
      tx_busy      <= 1'b0;
      tx_clear_req <= 1'b0;
    end else begin
      tx_start_q   <= tx_start;
      tx_clear_req <= 1'b0;
      if (!tx_start) tx_armed <= 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (tx_start && !tx_start_q && tx_armed) begin
            tx_state   <= TX_START;
            tx_shreg   <= tx_data;
            tx_clk_cnt <= 16'd0;
            tx_bit_idx <= 3'd0;
            tx_armed   <= 1'b0;
            ser_tx     <= 1'b0;
            tx_busy    <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_clk_cnt == BIT_LAST) begin
            tx_clk_cnt <= 16'd0;
            tx_state   <= TX_DATA;
            ser_tx     <= tx_shreg[0];
          end else begin
            tx_clk_cnt <= tx_clk_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_clk_cnt == BIT_LAST) begin
            tx_clk_cnt <= 16'd0;
            tx_bit_idx <= tx_bit_idx + 3'd1;
            if (tx_bit_idx == 3'd7) begin
              tx_state <= TX_STOP;
              ser_tx   <= 1'b1;
            end else begin
              ser_tx <= tx_shreg[tx_bit_idx + 3'd1];
            end
          end else begin
            tx_clk_cnt <= tx_clk_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_clk_cnt == BIT_LAST) begin
            tx_clk_cnt   <= 16'd0;
            tx_state     <= TX_IDLE;
            ser_tx       <= 1'b1;
            tx_busy      <= 1'b0;
            tx_clear_req <= 1'b1;
          end else begin
            tx_clk_cnt <= tx_clk_cnt + 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  tb_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .ser_rx       (ser_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

endmodule

// File: tb/tb_tb_uart.sv
// tb/tb_tb_uart.sv - self-checking bench for tb_uart with a cycle-level frame model
module tb_tb_uart;
  import tb_uart_pkg::*;

  localparam int CPB   = 16;
  localparam int CPB_L = 4167;

  logic       clk = 1'b0;
  logic       rst_n, ser_rx, tx_start;
  logic [7:0] tx_data;
  logic       ser_tx, tx_busy, tx_clear_req, rx_valid, rx_frame_err;
  logic [7:0] rx_data;
  logic       tx_start2;
  logic [7:0] tx_data2;
  logic       ser_tx2, tx_busy2, tx_clear_req2, rx_valid2, rx_frame_err2;
  logic [7:0] rx_data2;

  always #5 clk = ~clk;

  tb_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .ser_rx(ser_rx), .ser_tx(ser_tx),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_clear_req(tx_clear_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  tb_uart #(.CLKS_PER_BIT(CPB_L)) dut_lb (
    .clk(clk), .rst_n(rst_n), .ser_rx(ser_tx2), .ser_tx(ser_tx2),
    .tx_start(tx_start2), .tx_data(tx_data2), .tx_busy(tx_busy2),
    .tx_clear_req(tx_clear_req2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_frame_err(rx_frame_err2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t0;
  } rx_ev_t;

  logic [2:0] txq[$];
  rx_ev_t     rxq[$];
  logic [7:0] model_rx_data = 8'd0;
  int busy_run = 0, last_busy_len = 0, clr_count = 0, valid_count = 0, ferr_count = 0;
  int busy2_run = 0, busy2_len = 0, valid2_count = 0, ferr2_count = 0;
  logic [7:0] valid2_data = 8'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Expected line/busy/clear for every cycle of one frame, then the end-of-frame cycle.
  task automatic push_tx_frame(input logic [7:0] b);
    logic [9:0] f;
    f = frame_of(b);
    for (int k = 0; k < FRAME_BITS * CPB; k++) txq.push_back({f[k / CPB], 1'b1, 1'b0});
    txq.push_back(3'b101);
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    rx_ev_t     ev;
    int         lat;
    e = (txq.size() > 0) ? txq.pop_front() : 3'b100;
    check("ser_tx", 32'(ser_tx), 32'(e[2]));
    check("tx_busy", 32'(tx_busy), 32'(e[1]));
    check("tx_clear_req", 32'(tx_clear_req), 32'(e[0]));
    if (tx_busy) busy_run++;
    else if (busy_run > 0) begin last_busy_len = busy_run; busy_run = 0; end
    if (tx_clear_req) clr_count++;
    if (rx_valid || rx_frame_err) begin
      if (rxq.size() == 0) begin
        check("rx_unexpected_pulse", 32'({rx_valid, rx_frame_err}), 32'd0);
      end else begin
        ev  = rxq.pop_front();
        lat = cyc - ev.t0;
        check("rx_pulse_kind", 32'({rx_valid, rx_frame_err}), ev.err ? 32'd1 : 32'd2);
        check("rx_latency_in_145_165", 32'(lat >= 145 && lat <= 165), 32'd1);
        if (!ev.err) model_rx_data = ev.data;
      end
      if (rx_valid) valid_count++;
      if (rx_frame_err) ferr_count++;
    end
    check("rx_data", 32'(rx_data), 32'(model_rx_data));
    if (tx_busy2) busy2_run++;
    else if (busy2_run > 0) begin busy2_len = busy2_run; busy2_run = 0; end
    if (rx_valid2) begin valid2_count++; valid2_data = rx_data2; end
    if (rx_frame_err2) ferr2_count++;
  end

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    rx_ev_t     ev;
    f = {stop, b, 1'b0};
    @(negedge clk); #1;
    ev.err = !stop; ev.data = b; ev.t0 = cyc;
    rxq.push_back(ev);
    for (int k = 0; k < FRAME_BITS; k++) begin
      ser_rx = f[k];
      repeat (CPB) @(negedge clk);
      #1;
    end
    ser_rx = 1'b1;
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk); #1;
    tx_data  = b;
    tx_start = 1'b1;
    push_tx_frame(b);
  endtask

  task automatic wait_tx_done();
    int n = 0;
    while (txq.size() > 0 && n < 1000) begin @(negedge clk); n++; end
    check("tx_drain_timeout", 32'(txq.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int clr_before, n;
    rst_n = 1'b0; ser_rx = 1'b1; tx_start = 1'b0; tx_data = 8'd0;
    tx_start2 = 1'b0; tx_data2 = 8'd0;
    idle(3);
    check("reset_ser_tx", 32'(ser_tx), 32'd1);
    check("reset_tx_busy", 32'(tx_busy), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    check("model_frame_3d", 32'(frame_of(8'h3D)), 32'(10'b1001111010));
    check("model_frame_a5", 32'(frame_of(8'hA5)), 32'(10'b1101001010));
    idle(4);

    // 0x3D held high: one frame only
    start_tx(8'h3D);
    wait_tx_done();
    idle(100);
    check("tx1_busy_len", 32'(last_busy_len), 32'd160);
    check("tx1_clear_pulses", 32'(clr_count), 32'd1);
    tx_start = 1'b0;
    idle(5);

    // Data change and re-request mid-frame are ignored; RX runs concurrently
    fork
      begin
        start_tx(8'hC4);
        idle(40);
        tx_data = 8'hFF; tx_start = 1'b0;
        idle(5);
        tx_start = 1'b1;
      end
      rx_send(8'h55, 1'b1);
    join
    wait_tx_done();
    idle(30);
    check("tx2_busy_len", 32'(last_busy_len), 32'd160);
    check("tx2_clear_pulses", 32'(clr_count), 32'd2);
    check("rx_55_data", 32'(rx_data), 32'h55);
    check("rx_55_valid_count", 32'(valid_count), 32'd1);
    tx_start = 1'b0;

    // Short low glitch
    ser_rx = 1'b0;
    idle(4);
    ser_rx = 1'b1;
    idle(40);
    check("glitch_valid_count", 32'(valid_count), 32'd1);
    check("glitch_ferr_count", 32'(ferr_count), 32'd0);

    // Bad stop bit keeps previous byte
    rx_send(8'hA5, 1'b0);
    idle(30);
    check("ferr_count", 32'(ferr_count), 32'd1);
    check("ferr_rx_data_kept", 32'(rx_data), 32'h55);
    check("ferr_queue_empty", 32'(rxq.size()), 32'd0);

    rx_send(8'h96, 1'b1);
    idle(30);
    check("rx_96_data", 32'(rx_data), 32'h96);
    check("rx_96_queue_empty", 32'(rxq.size()), 32'd0);

    // Reset at cycle 50 of a frame, request still held through release
    start_tx(8'h3D);
    idle(49);
    clr_before = clr_count;
    rst_n = 1'b0;
    txq.delete();
    model_rx_data = 8'd0;
    idle(4);
    check("midreset_ser_tx", 32'(ser_tx), 32'd1);
    check("midreset_tx_busy", 32'(tx_busy), 32'd0);
    rst_n = 1'b1;
    idle(200);
    check("midreset_no_clear", 32'(clr_count), 32'(clr_before));
    tx_start = 1'b0;
    idle(3);
    start_tx(8'h81);
    wait_tx_done();
    tx_start = 1'b0;
    idle(10);
    check("rearm_clear_pulses", 32'(clr_count), 32'(clr_before + 1));

    // Long-bit loopback
    tx_data2 = 8'h0F; tx_start2 = 1'b1;
    n = 0;
    while ((busy2_len == 0 || valid2_count == 0) && n < 50000) begin @(negedge clk); n++; end
    #1;
    check("lb_busy_len", 32'(busy2_len), 32'd41670);
    check("lb_valid_count", 32'(valid2_count), 32'd1);
    check("lb_rx_data", 32'(valid2_data), 32'h0F);
    check("lb_ferr_count", 32'(ferr2_count), 32'd0);
    tx_start2 = 1'b0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
